// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and access sequencer for the 16-bit peripheral I/O bus.
// Each access runs as a fixed strobe / wait / ack sequence.
module io_bus_arbiter #(
    parameter int          RD_LAT   = 1,
    parameter logic [15:0] ERR_DATA = 16'h0666
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        err,
    output logic [7:0]  wait_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        last;
    logic        we_q;
    logic        map_q;
    logic [2:0]  cnt;
    logic        grant;
    logic        win;
    logic [15:0] win_addr;
    logic        waiting;

    function automatic logic is_mapped(input logic [15:0] a);
        return (a[15:8] == 8'h67) || (a[15:8] == 8'h68) ||
               (a[15:8] == 8'h69) || (a[15:8] == 8'h70) ||
               (a[15:8] == 8'h71);
    endfunction

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        grant    = m0_req | m1_req;
        win      = (m0_req & m1_req) ? ~last : m1_req;
        win_addr = win ? m1_addr : m0_addr;
    end

    always_comb begin
        state_nxt = state;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        err       = 1'b0;
        waiting   = 1'b0;
        unique case (state)
            IDLE: begin
                waiting = m0_req & m1_req;
                if (grant)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                bus_wr    = map_q & we_q;
                bus_rd    = map_q & ~we_q;
                waiting   = owner ? m0_req : m1_req;
                state_nxt = WAIT;
            end
            WAIT: begin
                waiting = owner ? m0_req : m1_req;
                if (cnt == 3'd0)
                    state_nxt = ACK;
            end
            ACK: begin
                m0_ack    = ~owner;
                m1_ack    = owner;
                err       = ~map_q;
                waiting   = owner ? m0_req : m1_req;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            we_q     <= 1'b0;
            map_q    <= 1'b0;
            cnt      <= 3'd0;
            bus_addr <= 16'h0000;
            bus_dout <= 16'h0000;
            m0_rdata <= 16'h0000;
            m1_rdata <= 16'h0000;
            wait_cnt <= 8'h00;
        end else begin
            state <= state_nxt;
            if (waiting && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'h01;
            if (state == IDLE && grant) begin
                owner    <= win;
                last     <= win;
                we_q     <= win ? m1_we : m0_we;
                map_q    <= is_mapped(win_addr);
                bus_addr <= win_addr;
                bus_dout <= win ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS)
                cnt <= LAT_M1;
            else if (state == WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            // Unmapped reads return the error pattern instead of the mux output.
            if (state == WAIT && cnt == 3'd0 && !we_q) begin
                if (owner)
                    m1_rdata <= map_q ? bus_din : ERR_DATA;
                else
                    m0_rdata <= map_q ? bus_din : ERR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: writes, reads, ties,
// unmapped access, reset mid-access and early request drop.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0;
    logic        m0_ack;
    logic [15:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m1_addr = 16'h0, m1_wdata = 16'h0;
    logic        m1_ack;
    logic [15:0] m1_rdata;
    logic        bus_rd, bus_wr, err;
    logic [15:0] bus_addr, bus_dout;
    logic [15:0] bus_din = 16'h0;
    logic [7:0]  wait_cnt;

    int vectors = 0;
    int miscompares = 0;

    io_bus_arbiter dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .m0_req(m0_req),
        .m0_we(m0_we),
        .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
        .m0_ack(m0_ack),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req),
        .m1_we(m1_we),
        .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_ack(m1_ack),
        .m1_rdata(m1_rdata),
        .bus_rd(bus_rd),
        .bus_wr(bus_wr),
        .bus_addr(bus_addr),
        .bus_dout(bus_dout),
        .bus_din(bus_din),
        .err(err),
        .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] a0;
        logic [15:0] a1;
        logic        w;

        // Reset state
        tick();
        tick();
        chk("rst_rd", bus_rd, 0);
        chk("rst_wr", bus_wr, 0);
        chk("rst_ack0", m0_ack, 0);
        chk("rst_ack1", m1_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_dout", bus_dout, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_wcnt", wait_cnt, 0);
        rst = 1'b1;

        // m0 write 0x6702 <- 0x1234
        m0_req = 1; m0_we = 1; m0_addr = 16'h6702; m0_wdata = 16'h1234;
        tick();
        chk("t1_wr", bus_wr, 1);
        chk("t1_rd", bus_rd, 0);
        chk("t1_dout", bus_dout, 16'h1234);
        chk("t1_addr", bus_addr, 16'h6702);
        chk("t1_ack_early", m0_ack, 0);
        tick();
        chk("t1_wr_wait", bus_wr, 0);
        chk("t1_addr_hold", bus_addr, 16'h6702);
        chk("t1_ack_wait", m0_ack, 0);
        tick();
        chk("t1_ack", m0_ack, 1);
        chk("t1_ack1", m1_ack, 0);
        chk("t1_err", err, 0);
        chk("t1_rdata", m0_rdata, 0);
        m0_req = 0;
        tick();
        chk("t1_ack_off", m0_ack, 0);
        chk("t1_wcnt", wait_cnt, 0);

        // m1 read 0x6904, bus_din = 0x00A5
        m1_req = 1; m1_we = 0; m1_addr = 16'h6904; bus_din = 16'h0;
        tick();
        chk("t2_rd", bus_rd, 1);
        chk("t2_wr", bus_wr, 0);
        bus_din = 16'h00A5;
        tick();
        chk("t2_rd_wait", bus_rd, 0);
        tick();
        chk("t2_ack", m1_ack, 1);
        chk("t2_ack0", m0_ack, 0);
        chk("t2_rdata", m1_rdata, 16'h00A5);
        m1_req = 0;
        tick();
        chk("t2_ack_off", m1_ack, 0);
        chk("t2_rdata_hold", m1_rdata, 16'h00A5);

        // m0 unmapped read 0x5500
        m0_req = 1; m0_we = 0; m0_addr = 16'h5500; bus_din = 16'hFFFF;
        tick();
        chk("t4_rd", bus_rd, 0);
        chk("t4_wr", bus_wr, 0);
        tick();
        tick();
        chk("t4_ack", m0_ack, 1);
        chk("t4_err", err, 1);
        chk("t4_rdata", m0_rdata, 16'h0666);
        chk("t4_rdata1", m1_rdata, 16'h00A5);
        m0_req = 0;
        tick();
        chk("t4_err_off", err, 0);

        // m1 drops req one cycle after grant
        m1_req = 1; m1_we = 0; m1_addr = 16'h6800; bus_din = 16'hBEEF;
        tick();
        chk("t6_rd", bus_rd, 1);
        m1_req = 0;
        tick();
        tick();
        chk("t6_ack", m1_ack, 1);
        chk("t6_rdata", m1_rdata, 16'hBEEF);
        tick();
        chk("t6_ack_off", m1_ack, 0);
        tick();
        chk("t6_no_rearm", bus_rd, 0);
        chk("t6_no_ack", m1_ack, 0);

        // reset low during WAIT
        m0_req = 1; m0_we = 0; m0_addr = 16'h7000; bus_din = 16'h1111;
        tick();
        chk("t5_rd", bus_rd, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_ack_rst", m0_ack, 0);
        chk("t5_rd_rst", bus_rd, 0);
        chk("t5_rdata_rst", m0_rdata, 0);
        rst = 1'b1;
        tick();
        chk("t5_rd_again", bus_rd, 1);
        chk("t5_addr", bus_addr, 16'h7000);
        tick();
        chk("t5_ack_wait", m0_ack, 0);
        tick();
        chk("t5_ack", m0_ack, 1);
        chk("t5_rdata", m0_rdata, 16'h1111);
        m0_req = 0;
        tick();

        // both masters request continuously after reset
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        a0 = 16'h6700;
        a1 = 16'h6800;
        m0_req = 1; m0_we = 0; m0_addr = a0;
        m1_req = 1; m1_we = 0; m1_addr = a1;
        bus_din = 16'h0042;
        w = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t3_addr%0d", k), bus_addr, w ? a1 : a0);
            chk($sformatf("t3_rd%0d", k), bus_rd, 1);
            tick();
            tick();
            chk($sformatf("t3_ack0_%0d", k), m0_ack, !w);
            chk($sformatf("t3_ack1_%0d", k), m1_ack, w);
            chk($sformatf("t3_wcnt%0d", k), wait_cnt, 16'(4 * k - 1));
            if (k == 4) begin
                m0_req = 0;
                m1_req = 0;
            end
            tick();
            w = ~w;
        end
        chk("t3_wcnt_end", wait_cnt, 15);
        chk("t3_rdata0", m0_rdata, 16'h0042);
        chk("t3_rdata1", m1_rdata, 16'h0042);
        chk("t3_idle_rd", bus_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
